// File: rtl/clock_display_scanner.sv
// -----------------------------------------------------------------------------
// clock_display_scanner
//
// Drives a 6-digit common-anode 7-segment display from the clock core's BCD
// time buses. One digit is enabled at a time for SCAN_DIV cycles. The time is
// captured once per frame so that a rollover in the middle of a scan cannot
// show a torn value.
//
// Parameters
//   SCAN_DIV   cycles each digit stays enabled (>= 2)
//   BLINK_DIV  cycles per blink half-period   (>= 2)
//
// Ports
//   clk         system clock
//   rst         synchronous reset, active low
//   hour        BCD hours   {tens, ones}
//   minute      BCD minutes {tens, ones}
//   second      BCD seconds {tens, ones}
//   mode        0 idle, 1 clock, 2 stopwatch, 3 timer
//   ring        alarm/timer ringing, blinks the whole display
//   led         alarm-armed indicator, shown on the dp of digit 0
//   an          digit enables, active low, bit 0 = seconds ones
//   seg         segments {g,f,e,d,c,b,a}, active low
//   dp          decimal point, active low
//   frame_tick  one-cycle pulse after the last cycle of digit 5
//   bcd_err     sticky flag: an invalid BCD nibble was captured
// -----------------------------------------------------------------------------
module clock_display_scanner #(
   parameter int SCAN_DIV  = 4,
   parameter int BLINK_DIV = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] hour,
   input  logic [7:0] minute,
   input  logic [7:0] second,
   input  logic [1:0] mode,
   input  logic       ring,
   input  logic       led,
   output logic [5:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       frame_tick,
   output logic       bcd_err
);

   localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
   localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

   localparam logic [1:0] MODE_IDLE  = 2'd0;
   localparam logic [1:0] MODE_CLOCK = 2'd1;

   localparam logic [2:0] DIGIT_FIRST = 3'd0;
   localparam logic [2:0] DIGIT_LAST  = 3'd5;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [SCAN_W-1:0]  scan_cnt;
   logic [2:0]         digit;
   logic [BLINK_W-1:0] blink_cnt;
   logic               blink_on;
   logic [7:0]         snap_hour;
   logic [7:0]         snap_minute;
   logic [7:0]         snap_second;

   // ---------------------------------------------------------------------------
   // Helpers
   // ---------------------------------------------------------------------------
   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = SEG_OFF;
      endcase
      return s;
   endfunction

   function automatic logic byte_bad(input logic [7:0] v);
      return (v[3:0] > 4'd9) || (v[7:4] > 4'd9);
   endfunction

   // ---------------------------------------------------------------------------
   // Frame values
   // ---------------------------------------------------------------------------
   logic       snap_now;
   logic       scan_wrap;
   logic       blink_wrap;
   logic [7:0] frame_hour;
   logic [7:0] frame_minute;
   logic [7:0] frame_second;
   logic       capture_err;

   assign snap_now   = (scan_cnt == '0) && (digit == DIGIT_FIRST);
   assign scan_wrap  = (scan_cnt == SCAN_LAST);
   assign blink_wrap = (blink_cnt == BLINK_LAST);

   // The digit-0 output is registered on the same edge that loads the
   // snapshot, so the incoming time is bypassed to keep the whole frame
   // on one coherent capture.
   assign frame_hour   = snap_now ? hour   : snap_hour;
   assign frame_minute = snap_now ? minute : snap_minute;
   assign frame_second = snap_now ? second : snap_second;

   assign capture_err = byte_bad(hour) || byte_bad(minute) || byte_bad(second);

   // ---------------------------------------------------------------------------
   // Next output values, derived from the current digit
   // ---------------------------------------------------------------------------
   logic [3:0] cur_nibble;
   logic       blank;
   logic       zero_blank;
   logic [5:0] an_next;
   logic [6:0] seg_next;
   logic       dp_next;
   logic       frame_end;

   always_comb begin
      cur_nibble = 4'd0;
      case (digit)
         3'd0:    cur_nibble = frame_second[3:0];
         3'd1:    cur_nibble = frame_second[7:4];
         3'd2:    cur_nibble = frame_minute[3:0];
         3'd3:    cur_nibble = frame_minute[7:4];
         3'd4:    cur_nibble = frame_hour[3:0];
         3'd5:    cur_nibble = frame_hour[7:4];
         default: cur_nibble = 4'd0;
      endcase
   end

   // Idle mode blanks everything; otherwise ringing blanks the off half of
   // the blink period and overrides every other display rule.
   assign blank = (mode == MODE_IDLE) || (ring && !blink_on);

   assign zero_blank = (mode == MODE_CLOCK) && (digit == DIGIT_LAST) &&
                       (frame_hour[7:4] == 4'd0);

   always_comb begin
      an_next  = '1;
      seg_next = SEG_OFF;
      dp_next  = 1'b1;
      if (!blank) begin
         an_next  = ~(6'b000001 << digit);
         seg_next = zero_blank ? SEG_OFF : seg_decode(cur_nibble);
         case (digit)
            3'd0:       dp_next = ~led;
            3'd2, 3'd4: dp_next = (mode == MODE_CLOCK) ? ~blink_on : 1'b0;
            default:    dp_next = 1'b1;
         endcase
      end
   end

   assign frame_end = (digit == DIGIT_LAST) && scan_wrap;

   // ---------------------------------------------------------------------------
   // Sequential logic
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         scan_cnt    <= '0;
         digit       <= DIGIT_FIRST;
         blink_cnt   <= '0;
         blink_on    <= 1'b1;
         snap_hour   <= '0;
         snap_minute <= '0;
         snap_second <= '0;
         an          <= '1;
         seg         <= SEG_OFF;
         dp          <= 1'b1;
         frame_tick  <= 1'b0;
         bcd_err     <= 1'b0;
      end else begin
         // digit scan
         if (scan_wrap) begin
            scan_cnt <= '0;
            digit    <= (digit == DIGIT_LAST) ? DIGIT_FIRST : digit + 3'd1;
         end else begin
            scan_cnt <= scan_cnt + 1'b1;
         end

         // blink timebase, free-running
         if (blink_wrap) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end

         // once-per-frame capture
         if (snap_now) begin
            snap_hour   <= hour;
            snap_minute <= minute;
            snap_second <= second;
            if (capture_err)
               bcd_err <= 1'b1;
         end

         an         <= an_next;
         seg        <= seg_next;
         dp         <= dp_next;
         frame_tick <= frame_end;
      end
   end

endmodule

// File: tb/tb_clock_display_scanner.sv
module tb_clock_display_scanner;

   localparam int SD    = 4;
   localparam int BD    = 64;
   localparam int FRAME = 6 * SD;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] hour, minute, second;
   logic [1:0] mode;
   logic       ring, led;
   logic [5:0] an;
   logic [6:0] seg;
   logic       dp, frame_tick, bcd_err;

   always #5 clk = ~clk;

   clock_display_scanner #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
      .clk(clk), .rst(rst), .hour(hour), .minute(minute), .second(second),
      .mode(mode), .ring(ring), .led(led), .an(an), .seg(seg), .dp(dp),
      .frame_tick(frame_tick), .bcd_err(bcd_err)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: everything is a function of k, the number of clock
   // edges since reset release, plus the time captured at each frame start.
   int         k = 0;
   int         exp_digit;
   logic       exp_bon;
   logic       exp_blank;
   logic [5:0] exp_an;
   logic [6:0] exp_seg;
   logic       exp_dp;
   logic       exp_ft;
   logic       exp_err;
   logic       m_err = 1'b0;
   logic [7:0] sh, sm, ss;

   logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'h7F, 7'h7F,
                                7'h7F, 7'h7F, 7'h7F, 7'h7F};

   function automatic logic bad8(input logic [7:0] v);
      return (v[3:0] > 4'd9) || (v[7:4] > 4'd9);
   endfunction

   task automatic cycle();
      logic [7:0] val;
      logic [3:0] nib;
      @(posedge clk);
      if (rst === 1'b0) begin
         k = 0; m_err = 1'b0; exp_digit = 0; exp_bon = 1'b1; exp_blank = 1'b1;
         exp_an = 6'h3F; exp_seg = 7'h7F; exp_dp = 1'b1; exp_ft = 1'b0;
      end else begin
         if (k % FRAME == 0) begin
            sh = hour; sm = minute; ss = second;
            if (bad8(hour) || bad8(minute) || bad8(second)) m_err = 1'b1;
         end
         exp_digit = (k / SD) % 6;
         exp_bon   = ((k / BD) % 2) == 0;
         exp_blank = (mode == 2'd0) || (ring && !exp_bon);
         val = (exp_digit < 2) ? ss : (exp_digit < 4) ? sm : sh;
         nib = (exp_digit % 2 == 1) ? val[7:4] : val[3:0];
         exp_seg = seg_tab[nib];
         if (mode == 2'd1 && exp_digit == 5 && nib == 4'd0) exp_seg = 7'h7F;
         exp_an = exp_blank ? 6'h3F : (6'h3F & ~(6'd1 << exp_digit));
         if (exp_blank)                          exp_dp = 1'b1;
         else if (exp_digit == 0)                exp_dp = ~led;
         else if (exp_digit == 2 || exp_digit == 4)
            exp_dp = (mode == 2'd1) ? ~exp_bon : 1'b0;
         else                                    exp_dp = 1'b1;
         exp_ft = (exp_digit == 5) && (k % SD == SD - 1);
         k++;
      end
      exp_err = m_err;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0; hour = 8'h12; minute = 8'h34; second = 8'h56;
      mode = 2'd1; ring = 1'b0; led = 1'b0;
      repeat (3) cycle();
      n_checks++; if (an !== 6'h3F) $display("FAIL reset_an got %h exp 3f", an); else n_pass++;
      n_checks++; if (seg !== 7'h7F) $display("FAIL reset_seg got %h exp 7f", seg); else n_pass++;
      n_checks++; if (dp !== 1'b1) $display("FAIL reset_dp got %b exp 1", dp); else n_pass++;
      n_checks++; if (frame_tick !== 1'b0) $display("FAIL reset_ft got %b exp 0", frame_tick); else n_pass++;
      n_checks++; if (bcd_err !== 1'b0) $display("FAIL reset_err got %b exp 0", bcd_err); else n_pass++;
      rst = 1'b1;
   endtask

   task automatic test_scan_walk();
      int ticks = 0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         cycle();
         if (frame_tick === 1'b1) ticks++;
         if (i == 0) begin
            n_checks++;
            if (an !== 6'b111110 || seg !== 7'b0000010)
               $display("FAIL walk_first an=%b seg=%b exp 111110/0000010", an, seg);
            else n_pass++;
         end
         n_checks++; if (an !== exp_an) $display("FAIL walk_an k=%0d got %b exp %b", k, an, exp_an); else n_pass++;
         n_checks++; if (seg !== exp_seg) $display("FAIL walk_seg k=%0d got %b exp %b", k, seg, exp_seg); else n_pass++;
         n_checks++; if (frame_tick !== exp_ft) $display("FAIL walk_ft k=%0d got %b exp %b", k, frame_tick, exp_ft); else n_pass++;
      end
      n_checks++; if (ticks != 2) $display("FAIL walk_tick_count got %0d exp 2", ticks); else n_pass++;
   endtask

   task automatic test_leading_zero();
      for (int pass = 0; pass < 2; pass++) begin
         hour = 8'h09; mode = (pass == 0) ? 2'd1 : 2'd2;
         repeat (FRAME) cycle();
         for (int i = 0; i < FRAME; i++) begin
            cycle();
            if (exp_digit == 5) begin
               n_checks++;
               if (an !== 6'b011111 || seg !== ((pass == 0) ? 7'h7F : 7'b1000000))
                  $display("FAIL lead_zero mode=%0d an=%b seg=%b", mode, an, seg);
               else n_pass++;
            end
         end
      end
      mode = 2'd1; hour = 8'h12;
   endtask

   task automatic test_coherence();
      int seen = 0;
      minute = 8'h59; second = 8'h59;
      repeat (FRAME) cycle();
      for (int i = 0; i < FRAME && exp_digit != 1; i++) cycle();
      minute = 8'h00; second = 8'h00;
      for (int i = 0; i < 2 * FRAME; i++) begin
         cycle();
         n_checks++; if (seg !== exp_seg) $display("FAIL coh_seg k=%0d got %b exp %b", k, seg, exp_seg); else n_pass++;
         if (exp_digit == 2 && seen < SD) begin
            seen++;
            n_checks++; if (seg !== 7'b0010000) $display("FAIL coh_old_min got %b exp 0010000", seg); else n_pass++;
         end else if (exp_digit == 2) begin
            n_checks++; if (seg !== 7'b1000000) $display("FAIL coh_new_min got %b exp 1000000", seg); else n_pass++;
         end
      end
   endtask

   task automatic test_dp_led();
      mode = 2'd1; led = 1'b1; ring = 1'b0;
      for (int i = 0; i < 2 * BD; i++) begin
         cycle();
         n_checks++; if (dp !== exp_dp) $display("FAIL dp k=%0d digit=%0d got %b exp %b", k, exp_digit, dp, exp_dp); else n_pass++;
         if (exp_digit == 0) begin
            n_checks++; if (dp !== 1'b0) $display("FAIL dp_led got %b exp 0", dp); else n_pass++;
         end
      end
      mode = 2'd3;
      for (int i = 0; i < BD; i++) begin
         cycle();
         if (exp_digit == 2 || exp_digit == 4) begin
            n_checks++; if (dp !== 1'b0) $display("FAIL dp_steady got %b exp 0", dp); else n_pass++;
         end
      end
      mode = 2'd1; led = 1'b0;
   endtask

   task automatic test_ring();
      int blanks = 0;
      ring = 1'b1;
      for (int i = 0; i < 4 * BD; i++) begin
         cycle();
         if (an === 6'h3F) blanks++;
         n_checks++; if (an !== exp_an) $display("FAIL ring_an k=%0d got %b exp %b", k, an, exp_an); else n_pass++;
      end
      n_checks++; if (blanks != 2 * BD) $display("FAIL ring_blank_count got %0d exp %0d", blanks, 2 * BD); else n_pass++;
      ring = 1'b0;
      for (int i = 0; i < BD; i++) begin
         cycle();
         n_checks++; if (an === 6'h3F) $display("FAIL ring_off_an k=%0d got 3f exp scanning", k); else n_pass++;
      end
   endtask

   task automatic test_bcd_err();
      rst = 1'b0; cycle(); rst = 1'b1;
      second = 8'h5A; hour = 8'h12; minute = 8'h34;
      cycle();
      n_checks++; if (seg !== 7'h7F) $display("FAIL err_seg got %b exp 7f", seg); else n_pass++;
      n_checks++; if (bcd_err !== 1'b1) $display("FAIL err_set got %b exp 1", bcd_err); else n_pass++;
      second = 8'h21;
      for (int i = 0; i < 2 * FRAME; i++) begin
         cycle();
         n_checks++; if (bcd_err !== 1'b1) $display("FAIL err_sticky k=%0d got %b exp 1", k, bcd_err); else n_pass++;
      end
      rst = 1'b0; cycle();
      n_checks++; if (bcd_err !== 1'b0) $display("FAIL err_clear got %b exp 0", bcd_err); else n_pass++;
      rst = 1'b1;
   endtask

   task automatic test_reset_mid_frame();
      mode = 2'd1; ring = 1'b0;
      repeat (FRAME) cycle();
      for (int i = 0; i < FRAME && exp_digit != 3; i++) cycle();
      rst = 1'b0; cycle();
      n_checks++; if (an !== 6'h3F || seg !== 7'h7F || dp !== 1'b1)
         $display("FAIL mid_reset an=%b seg=%b dp=%b exp 3f/7f/1", an, seg, dp); else n_pass++;
      rst = 1'b1;
      for (int i = 0; i < SD; i++) begin
         cycle();
         n_checks++; if (an !== 6'b111110) $display("FAIL mid_restart i=%0d got %b exp 111110", i, an); else n_pass++;
      end
      cycle();
      n_checks++; if (an !== 6'b111101) $display("FAIL mid_next got %b exp 111101", an); else n_pass++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 15) == 0) begin
            hour   = ($urandom_range(0, 9) == 0) ? 8'($urandom) : {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9))};
            minute = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
            second = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
         end
         if ($urandom_range(0, 31) == 0) mode = 2'($urandom);
         if ($urandom_range(0, 63) == 0) ring = 1'($urandom);
         if ($urandom_range(0, 15) == 0) led  = 1'($urandom);
         if ($urandom_range(0, 499) == 0) rst = 1'b0; else rst = 1'b1;
         cycle();
         n_checks++; if (an !== exp_an) $display("FAIL rnd_an k=%0d got %b exp %b", k, an, exp_an); else n_pass++;
         if (!exp_blank) begin
            n_checks++; if (seg !== exp_seg) $display("FAIL rnd_seg k=%0d got %b exp %b", k, seg, exp_seg); else n_pass++;
         end
         n_checks++; if (dp !== exp_dp) $display("FAIL rnd_dp k=%0d got %b exp %b", k, dp, exp_dp); else n_pass++;
         n_checks++; if (frame_tick !== exp_ft) $display("FAIL rnd_ft k=%0d got %b exp %b", k, frame_tick, exp_ft); else n_pass++;
         n_checks++; if (bcd_err !== exp_err) $display("FAIL rnd_err k=%0d got %b exp %b", k, bcd_err, exp_err); else n_pass++;
      end
      rst = 1'b1;
   endtask

   initial begin
      test_reset();
      test_scan_walk();
      test_leading_zero();
      test_coherence();
      test_dp_led();
      test_ring();
      test_bcd_err();
      test_reset_mid_frame();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/clock_display_scanner.md
Name: clock_display_scanner

Overview:
Consumer end of the clock core's time outputs. Takes the BCD hour/minute/second buses, plus mode, ring and led, and time-multiplexes them onto a 6-digit common-anode 7-segment display. Sits between multi-function clock core outputs and board pins. Latches a coherent time snapshot once per frame, so a digit rollover mid-scan never shows a torn value.

Parameters:
SCAN_DIV, 4, clock cycles each digit stays enabled (min 2)
BLINK_DIV, 64, clock cycles per blink half-period (min 2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
hour  in  8  BCD hours {tens,ones} from clock core
minute  in  8  BCD minutes
second  in  8  BCD seconds
mode  in  2  0 idle, 1 clock, 2 stopwatch, 3 timer
ring  in  1  alarm/timer ringing
led  in  1  alarm-armed indicator, passed to dp of digit 0
an  out  6  digit enables, active-low, bit0 = seconds ones
seg  out  7  segments {g,f,e,d,c,b,a}, active-low
dp  out  1  decimal point, active-low
frame_tick  out  1  one-cycle pulse at end of digit 5
bcd_err  out  1  sticky: invalid BCD nibble captured

Behaviour:
- Reset (rst=0 at clk edge): scan_cnt=0, digit=0, blink_cnt=0, blink_on=1, snapshot regs=0.
  Outputs: an=6'h3F, seg=7'h7F, dp=1, frame_tick=0, bcd_err=0.
- scan_cnt counts 0..SCAN_DIV-1 and wraps. On wrap, digit advances 0→1→…→5→0.
- Snapshot: when scan_cnt==0 and digit==0 (including the first cycle after reset release), register hour/minute/second. All six digits of a frame use this snapshot.
- Digit map:
  - 0 = sec[3:0], 1 = sec[7:4]
  - 2 = min[3:0], 3 = min[7:4]
  - 4 = hr[3:0], 5 = hr[7:4]
- All outputs are registered from current state. Latency is one cycle: an/seg for digit d appear the cycle after digit becomes d.
- an: exactly one bit low, an[digit]=0, except during blanking, when an=6'h3F.
- Segment encoding, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Invalid nibble (>9): seg=7'h7F for that digit. bcd_err set on snapshot capture of any invalid nibble. bcd_err cleared only by reset.
- Leading-zero blank: mode==1 and hr tens==0 → digit 5 seg=7'h7F (an still asserted).
- mode==0: all digits blank (an=6'h3F). Scanning, snapshot and frame_tick continue.
- Blink: blink_cnt counts 0..BLINK_DIV-1. On wrap, blink_on toggles. blink_cnt runs independent of scan.
- ring==1 and blink_on==0: an=6'h3F. ring has priority over all other display rules except mode==0.
- dp:
  - digits 2 and 4: dp=0 in modes 2/3 steady; in mode 1, dp = ~blink_on (colon blinks).
  - digit 0: dp = ~led.
  - all other digits dp=1.
  - dp is gated by the same blanking as an.
- frame_tick=1 for the single cycle in which digit==5 and scan_cnt==SCAN_DIV-1 (registered: visible next cycle).
- Input change mid-frame: ignored until next snapshot.
- Reset mid-scan: returns to digit 0 next cycle, outputs off for that cycle.
- Mode/ring change: takes effect at the next registered output, without waiting for frame end.

Test Plan:
- Reset then release, mode=1, h=8'h12 m=8'h34 s=8'h56, SCAN_DIV=4 → an walks 111110…011111 every 4 cycles; seg sequence 0010010(5)? No—digit0 = 6 → 0000010, then 5, 4, 3, 2, 1; frame_tick every 24 cycles.
- mode=1, h=8'h09 → digit 5 seg=7'h7F with an[5]=0. Same with mode=2 → digit 5 shows 0 (1000000).
- Change s from 8'h59 to 8'h00 while digit==3 → remainder of frame still shows 59; next frame shows 00.
- Snapshot s=8'h5A → digit 0 seg=7'h7F, bcd_err=1, which persists after s returns to valid until rst=0.
- ring=1, BLINK_DIV=64 → an=6'h3F for 64 cycles, scanning for 64 cycles, repeating. ring=0 → continuous scan.
- mode=1, led=1: dp=0 on digit 0. dp on digits 2/4 toggles every 64 cycles. rst=0 mid-frame → next cycle an=6'h3F, digit restarts at 0.
